msk_clyde_inv_lin_stage: RTL and testbench
==========================================

Name: msk_clyde_inv_lin_stage

Overview:
- Registered, handshaked stage that applies the linear part of one Clyde-128 inverse round to a masked 128-bit state.
- Data path: optional round-constant injection, then the masked inverse L-box on row pairs (0,1) and (2,3).
- Sits between the masked tweakey-addition stage (upstream) and the masked inverse S-box layer (downstream) in the decryption datapath.
- Purely affine on shares: no randomness is consumed, and shares are never recombined.

Parameters:
- d, 2, number of shares (masking order + 1).
- SERIAL, 0, 0 = two inverse-L-box instances, one row pair each; 1 = one instance time-multiplexed over both pairs.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream state is valid
- in_ready  output  1  stage accepts in_state this cycle
- in_state  input  128*d  masked state, bit-interleaved sharing (bit i of row j at [(32*j+i)*d +: d])
- in_rc  input  4  public round constant, present only with MSK_INV_LIN_RC_EN
- out_valid  output  1  out_state holds a processed state
- out_ready  input  1  downstream accepts out_state
- out_state  output  128*d  processed masked state, same layout as in_state
- busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Row j = in_state[32*d*(j+1)-1 : 32*d*j].
- Inverse L-box instance A: x=row0, y=row1 -> new row0, row1.
- Inverse L-box instance B: x=row2, y=row3 -> new row2, row3.
- Inverse L-box is combinational and share-wise affine.
- State register sreg[128*d], 2-bit FSM:
  - IDLE: in_ready=1, out_valid=0.
    - in_valid & SERIAL=0: sreg <= both pairs transformed -> FULL.
    - in_valid & SERIAL=1: sreg <= pair 0 transformed, pair 1 raw -> HALF.
  - HALF (SERIAL=1 only): in_ready=0, out_valid=0. sreg pair 1 <= transformed from sreg, pair 0 held -> FULL. The single instance input mux selects in_state pair 0 in IDLE and sreg pair 1 in HALF.
  - FULL: out_valid=1, out_state=sreg.
    - in_ready = out_ready (combinational).
    - out_ready & in_valid: accept new state as in IDLE (-> FULL for SERIAL=0, -> HALF for SERIAL=1).
    - out_ready & !in_valid: -> IDLE.
    - !out_ready: hold sreg and out_state stable.
- Latency from accept to out_valid: 1 cycle (SERIAL=0), 2 cycles (SERIAL=1).
- Throughput: 1 state/cycle (SERIAL=0), 1 state/2 cycles (SERIAL=1).
- out_state is driven directly from sreg, so no combinational input-to-output path on data.
- Reset (rst=1 at clk edge): FSM=IDLE, sreg=0, out_valid=0, busy=0; in_ready=1 from the cycle after reset.
- Reset mid-operation (HALF or FULL) discards the state; no output is produced.
- Reset has priority over all handshakes.
- in_valid with in_ready=0 is ignored; upstream must hold the state until accepted.
- Encoding of FSM state 3 is unreachable; it decodes to IDLE on the next edge.

Optional Feature:
- Macro MSK_INV_LIN_RC_EN defined:
  - in_rc port exists.
  - Before the inverse L-box, in_rc[j] is XORed into share 0 of bit 0 of row j (index 32*j*d); other shares are untouched.
  - In SERIAL=1, in_rc is sampled on accept and held in a 4-bit register for the HALF cycle. Register reset value 0.
- Macro not defined: no in_rc port, no constant logic; the stage is the bare inverse linear layer.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, busy=0, out_state=0; in_ready=1 on the first cycle after rst falls.
- Zero state: in_state=0 (all shares zero), rc=0 -> exactly one out_valid pulse after 1 cycle (SERIAL=0) or 2 cycles (SERIAL=1); out_state=0.
- Random masked state, d=2: unmasked rows {0x01234567, 0x89ABCDEF, 0xDEADBEEF, 0x0BADF00D} with random share-1 masks -> XOR of output shares equals the team C model of inverse L-box per pair; rerun with different masks -> identical recombined value.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> out_state stable, in_ready=0; then out_ready=1 -> the next state is accepted the same cycle (SERIAL=0 back-to-back, one state per cycle for 8 states, in order).
- Reset in HALF (SERIAL=1): assert rst the cycle after accept -> no out_valid; the next accepted state is processed correctly.
- MSK_INV_LIN_RC_EN with in_rc=4'b1010 on a zero state -> recombined output equals the C model inverse L-box of rows {0,1,0,1}; share 1 remains 0.

Source files
------------

// File: rtl/msk_clyde_inv_lin_stage.sv
// Masked Clyde-128 inverse linear layer stage (optional round constant, inverse L-box on row pairs).
// Latency: 1 cycle accept->out_valid when SERIAL=0, 2 cycles when SERIAL=1.
// Backpressure: holds out_state while out_ready=0; in_ready follows out_ready in FULL, 0 in HALF.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake, in_state = 128*d bit-interleaved masked state
//   in_rc             4-bit public round constant (only with MSK_INV_LIN_RC_EN defined)
//   out_valid/out_ready downstream handshake, out_state driven straight from the state register
//   busy              high whenever the FSM is not IDLE
// Optional feature macro: MSK_INV_LIN_RC_EN (round-constant injection into share 0).
module msk_clyde_inv_lin_stage #(
    parameter int d      = 2,
    parameter int SERIAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [128*d-1:0]  in_state,
`ifdef MSK_INV_LIN_RC_EN
    input  logic [3:0]        in_rc,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [128*d-1:0]  out_state,
    output logic              busy
);

    localparam int RW = 32 * d;   // one row, all shares
    localparam int SW = 128 * d;  // whole state

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        FULL = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   sreg_q, sreg_d;
    logic            out_valid_q, busy_q;
    logic            accept;
    logic [SW-1:0]   in_x;          // in_state after round-constant injection
    logic [2*RW-1:0] pair0_nxt, pair1_nxt;

    // Rotating a bit-interleaved row right by n bit positions moves every share
    // together, i.e. a rotation of the packed vector by n*d.
    function automatic logic [RW-1:0] rotr(input logic [RW-1:0] v, input int n);
        logic [2*RW-1:0] t;
        t = {v, v} >> (n * d);
        return t[RW-1:0];
    endfunction

    // Inverse L-box; linear, so applying it to the packed shares is share-wise.
    // Returns {y', x'} to match the row-pair packing {row(2k+1), row(2k)}.
    function automatic logic [2*RW-1:0] lbox_inv(input logic [RW-1:0] x, input logic [RW-1:0] y);
        logic [RW-1:0] a, b, c, e;
        a = x ^ rotr(x, 25);
        b = y ^ rotr(y, 25);
        c = x ^ rotr(a, 31);
        e = y ^ rotr(b, 31);
        c = c ^ rotr(a, 20);
        e = e ^ rotr(b, 20);
        a = c ^ rotr(c, 31);
        b = e ^ rotr(e, 31);
        c = c ^ rotr(b, 26);
        e = e ^ rotr(a, 25);
        a = a ^ rotr(c, 17);
        b = b ^ rotr(e, 17);
        return {rotr(b, 16), rotr(a, 16)};
    endfunction

`ifdef MSK_INV_LIN_RC_EN
    // Constant bit lands on share 0 of bit 0 of each row of the pair.
    function automatic logic [2*RW-1:0] rc_pair(input logic [1:0] rc);
        logic [2*RW-1:0] v;
        v     = '0;
        v[0]  = rc[0];
        v[RW] = rc[1];
        return v;
    endfunction

    assign in_x = in_state ^ {rc_pair(in_rc[3:2]), rc_pair(in_rc[1:0])};
`else
    assign in_x = in_state;
`endif

    assign accept = in_valid && in_ready;

    if (SERIAL == 0) begin : g_par
        assign pair0_nxt = lbox_inv(in_x[RW-1:0],    in_x[2*RW-1:RW]);
        assign pair1_nxt = lbox_inv(in_x[3*RW-1:2*RW], in_x[4*RW-1:3*RW]);
    end else begin : g_ser
        logic [2*RW-1:0] sreg_hi_x;
        logic [2*RW-1:0] lb_in, lb_out;
`ifdef MSK_INV_LIN_RC_EN
        // Pair 1 is stored raw, so its constant bits wait here for the HALF cycle.
        logic [3:0] rc_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                rc_q <= '0;
            end else if (accept) begin
                rc_q <= in_rc;
            end
        end
        assign sreg_hi_x = sreg_q[SW-1:2*RW] ^ rc_pair(rc_q[3:2]);
`else
        assign sreg_hi_x = sreg_q[SW-1:2*RW];
`endif
        // Single instance: fresh pair 0 on accept, stored pair 1 during HALF.
        assign lb_in     = (state_q == HALF) ? sreg_hi_x : in_x[2*RW-1:0];
        assign lb_out    = lbox_inv(lb_in[RW-1:0], lb_in[2*RW-1:RW]);
        assign pair0_nxt = lb_out;
        assign pair1_nxt = lb_out;
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        case (state_q)
            IDLE, FULL: begin
                if (accept) begin
                    if (SERIAL != 0) begin
                        sreg_d  = {in_state[SW-1:2*RW], pair0_nxt};
                        state_d = HALF;
                    end else begin
                        sreg_d  = {pair1_nxt, pair0_nxt};
                        state_d = FULL;
                    end
                end else if ((state_q == FULL) && out_ready) begin
                    state_d = IDLE;
                end
            end
            HALF: begin
                sreg_d  = {pair1_nxt, sreg_q[2*RW-1:0]};
                state_d = FULL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            out_valid_q <= (state_d == FULL);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == FULL) && out_ready);
    assign out_valid = out_valid_q;
    assign out_state = sreg_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_msk_clyde_inv_lin_stage.sv
module tb_msk_clyde_inv_lin_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [255:0] in_state  [2];
    logic [3:0]   in_rc     [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [255:0] out_state [2];
    logic         busy      [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] exp;
        bit           s1z;
        int           lat;
        int           acc;
    } item_t;

    item_t q0[$];
    item_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msk_clyde_inv_lin_stage #(.d(2), .SERIAL(0)) u_par (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
`ifdef MSK_INV_LIN_RC_EN
        .in_rc(in_rc[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]),
        .busy(busy[0])
    );

    msk_clyde_inv_lin_stage #(.d(2), .SERIAL(1)) u_ser (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
`ifdef MSK_INV_LIN_RC_EN
        .in_rc(in_rc[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]),
        .busy(busy[1])
    );

    // ---------------- reference model (unmasked, C style) ----------------
    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] ref_lbox_inv(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, c, e;
        a = x ^ ror32(x, 25);  b = y ^ ror32(y, 25);
        c = x ^ ror32(a, 31);  e = y ^ ror32(b, 31);
        c = c ^ ror32(a, 20);  e = e ^ ror32(b, 20);
        a = c ^ ror32(c, 31);  b = e ^ ror32(e, 31);
        c = c ^ ror32(b, 26);  e = e ^ ror32(a, 25);
        a = a ^ ror32(c, 17);  b = b ^ ror32(e, 17);
        return {ror32(b, 16), ror32(a, 16)};
    endfunction

    function automatic logic [127:0] ref_stage(input logic [127:0] u, input logic [3:0] rc);
        logic [127:0] v;
        v = u;
        for (int j = 0; j < 4; j++) v[32*j] = v[32*j] ^ rc[j];
        return {ref_lbox_inv(v[95:64], v[127:96]), ref_lbox_inv(v[31:0], v[63:32])};
    endfunction

    function automatic logic [255:0] mask(input logic [127:0] u, input logic [127:0] m);
        logic [255:0] o;
        for (int k = 0; k < 128; k++) begin
            o[2*k]   = u[k] ^ m[k];
            o[2*k+1] = m[k];
        end
        return o;
    endfunction

    function automatic logic [127:0] unmask(input logic [255:0] o);
        logic [127:0] u;
        for (int k = 0; k < 128; k++) u[k] = o[2*k] ^ o[2*k+1];
        return u;
    endfunction

    function automatic logic [127:0] share1(input logic [255:0] o);
        logic [127:0] s;
        for (int k = 0; k < 128; k++) s[k] = o[2*k+1];
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic compare(input int k, input item_t it);
        chk($sformatf("dut%0d_value", k), unmask(out_state[k]), it.exp);
        if (it.s1z) chk($sformatf("dut%0d_share1_zero", k), share1(out_state[k]), 128'h0);
        if (it.lat >= 0) chk($sformatf("dut%0d_latency", k), 128'(cyc - it.acc), 128'(it.lat));
    endtask

    always @(negedge clk) begin
        if (out_valid[0] === 1'b1 && out_ready[0] === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_output: got %h expected none", unmask(out_state[0]));
            end else begin
                compare(0, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid[1] === 1'b1 && out_ready[1] === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_output: got %h expected none", unmask(out_state[1]));
            end else begin
                compare(1, q1.pop_front());
            end
        end
    end

    // Present one state, wait (bounded) for acceptance, push the expectation.
    task automatic send(input int k, input logic [127:0] u, input logic [127:0] m,
                        input logic [3:0] rc, input bit push, input bit s1z,
                        input int lat, output int acc);
        item_t it;
        in_valid[k] = 1'b1;
        in_state[k] = mask(u, m);
        in_rc[k]    = rc;
        acc = -1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready[k] === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL dut%0d_accept_timeout: got no in_ready expected acceptance", k);
        end else if (push) begin
            it.exp = ref_stage(u, rc);
            it.s1z = s1z;
            it.lat = lat;
            it.acc = acc;
            if (k == 0) q0.push_back(it); else q1.push_back(it);
        end
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    localparam logic [127:0] ROWS = {32'h0BADF00D, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567};

    initial begin
        int a, b, prev, rdy_cyc;
        logic [127:0] u, exp_a;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b1;
            in_state[k]  = {8{32'hA5A5_5A5A}};
            in_rc[k]     = 4'h0;
            out_ready[k] = 1'b1;
        end

        // Reset held 3 cycles with in_valid asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d_rst_out_valid", k), 128'(out_valid[k]), 128'h0);
            chk($sformatf("dut%0d_rst_busy", k), 128'(busy[k]), 128'h0);
            chk($sformatf("dut%0d_rst_out_state", k), out_state[k][127:0] | out_state[k][255:128], 128'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("dut%0d_in_ready_after_rst", k), 128'(in_ready[k]), 128'h1);
        @(posedge clk); #1;

        // Zero state: output zero, exact latency
        send(0, 128'h0, 128'h0, 4'h0, 1'b1, 1'b1, 1, a);
        send(1, 128'h0, 128'h0, 4'h0, 1'b1, 1'b1, 2, a);
        repeat (4) @(posedge clk); #1;

        // Masked random shares, two different masks each
        for (int r = 0; r < 2; r++) begin
            send(0, ROWS, rnd128(), 4'h0, 1'b1, 1'b0, 1, a);
            send(1, ROWS, rnd128(), 4'h0, 1'b1, 1'b0, 2, a);
        end
        repeat (4) @(posedge clk); #1;

        // Backpressure on the parallel stage, then back-to-back burst of 8
        out_ready[0] = 1'b0;
        exp_a = ref_stage(ROWS, 4'h0);
        send(0, ROWS, rnd128(), 4'h0, 1'b1, 1'b0, -1, a);
        fork
            send(0, 128'h1, rnd128(), 4'h0, 1'b1, 1'b0, -1, b);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_out_valid", 128'(out_valid[0]), 128'h1);
                    chk("bp_in_ready", 128'(in_ready[0]), 128'h0);
                    chk("bp_out_state_stable", unmask(out_state[0]), exp_a);
                end
                @(posedge clk); #1;
                out_ready[0] = 1'b1;
                rdy_cyc = cyc;
            end
        join
        chk("bp_accept_same_cycle", 128'(b), 128'(rdy_cyc));
        prev = b;
        for (int i = 0; i < 6; i++) begin
            u = {32'(i), 32'hFFFF_0000 ^ 32'(i), 32'h8000_0001 << i, 32'h1 << (3 * i)};
            send(0, u, rnd128(), 4'h0, 1'b1, 1'b0, -1, a);
            chk("burst_one_per_cycle", 128'(a - prev), 128'h1);
            prev = a;
        end
        repeat (4) @(posedge clk); #1;

        // Serial stage: one state per two cycles
        send(1, 128'h5, rnd128(), 4'h0, 1'b1, 1'b0, 2, prev);
        for (int i = 0; i < 2; i++) begin
            send(1, ROWS ^ {4{32'(i + 7)}}, rnd128(), 4'h0, 1'b1, 1'b0, 2, a);
            chk("serial_two_cycle_rate", 128'(a - prev), 128'h2);
            prev = a;
        end
        repeat (4) @(posedge clk); #1;

        // Reset while the serial stage is in HALF: state discarded
        send(1, ROWS, rnd128(), 4'h0, 1'b0, 1'b0, -1, a);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("half_rst_no_out_valid", 128'(out_valid[1]), 128'h0);
        end
        @(posedge clk); #1;
        send(1, ROWS, rnd128(), 4'h0, 1'b1, 1'b0, 2, a);
        repeat (4) @(posedge clk); #1;

`ifdef MSK_INV_LIN_RC_EN
        // Round constant 1010 on a zero state: rows {0,1,0,1}, share 1 stays zero
        send(0, 128'h0, 128'h0, 4'b1010, 1'b1, 1'b1, 1, a);
        send(1, 128'h0, 128'h0, 4'b1010, 1'b1, 1'b1, 2, a);
        repeat (4) @(posedge clk); #1;
`endif

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("dut0_scoreboard_drained", 128'(q0.size()), 128'h0);
        chk("dut1_scoreboard_drained", 128'(q1.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected summary before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
